// File: rtl/gmii_frame_gen.sv
// GMII Ethernet test-frame generator: preamble/SFD, MACs, EtherType, pattern payload and
// an in-line CRC-32 FCS. Supports single, burst and continuous modes with a fixed IFG.
module gmii_frame_gen #(
    parameter logic [47:0] DST_MAC = 48'hDA0203040506,
    parameter logic [47:0] SRC_MAC = 48'h5A0203040506,
    parameter int unsigned LEN_W   = 11,
    parameter int unsigned MAX_LEN = 1500,
    parameter int unsigned MIN_IFG = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tx_en,
    input  logic [1:0]       mode,
    input  logic [15:0]      burst_cnt,
    input  logic [LEN_W-1:0] payload_len,
    input  logic [15:0]      eth_type,
    input  logic [1:0]       pattern_sel,
    input  logic             err_inj_en,
    input  logic [LEN_W-1:0] err_inj_idx,
    output logic [7:0]       gmii_txd,
    output logic             gmii_tx_en,
    output logic             gmii_tx_er,
    output logic             busy,
    output logic             frame_done,
    output logic [15:0]      frames_sent
);

    localparam logic [LEN_W-1:0] MinLen  = LEN_W'(46);
    localparam logic [LEN_W-1:0] MaxLen  = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] IfgLast = LEN_W'(MIN_IFG - 1);
    localparam logic [31:0]      CrcPoly = 32'hEDB88320;

    typedef enum logic [3:0] {
        StIdle, StPre, StSfd, StDst, StSrc, StType, StPay, StFcs, StIfg
    } state_e;

    state_e           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             tx_en_q;

    // Per-sequence configuration
    logic [1:0]       mode_q;
    logic [15:0]      frames_left_q;

    // Per-frame configuration
    logic [LEN_W-1:0] len_q;
    logic [15:0]      type_q;
    logic [1:0]       pat_q;
    logic [7:0]       pat_byte_q;
    logic             err_en_q;
    logic [LEN_W-1:0] err_idx_q;

    logic [31:0]      crc_q;

    logic [7:0]       txd_q, txd_d;
    logic             gmii_tx_en_q, gmii_tx_en_d;
    logic             gmii_tx_er_q, gmii_tx_er_d;
    logic             busy_q;
    logic             done_pend_q;
    logic             frame_done_q;
    logic [15:0]      frames_sent_q;

    logic             start;
    logic             load_frame;
    logic             frame_end;
    logic             burst_abort;
    logic             crc_upd;
    logic [LEN_W-1:0] len_clamped;
    logic [7:0]       fs_now;
    logic [47:0]      dst_sh, src_sh;
    logic [31:0]      crc_sh;

    function automatic logic [31:0] crc_next(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc ^ {24'd0, d};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CrcPoly) : (c >> 1);
        end
        return c;
    endfunction

    assign start       = tx_en && !tx_en_q && (state_q == StIdle);
    assign load_frame  = (state_d == StPre) && (state_q != StPre);
    assign frame_end   = (state_q == StFcs) && (cnt_q[1:0] == 2'd3);
    assign burst_abort = (mode_q == 2'd1) && (frames_left_q == 16'd0);

    assign len_clamped = (payload_len < MinLen) ? MinLen :
                         (payload_len > MaxLen) ? MaxLen : payload_len;

    // A frame may end on the same edge that loads the next one when MIN_IFG is 1
    assign fs_now = frames_sent_q[7:0] + {7'd0, done_pend_q};

    assign dst_sh = DST_MAC << {cnt_q[2:0], 3'b000};
    assign src_sh = SRC_MAC << {cnt_q[2:0], 3'b000};
    assign crc_sh = crc_q >> {cnt_q[1:0], 3'b000};

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + LEN_W'(1);
        txd_d        = 8'h00;
        gmii_tx_en_d = 1'b0;
        gmii_tx_er_d = 1'b0;
        crc_upd      = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (start) begin
                    state_d = StPre;
                end
            end
            StPre: begin
                if ((cnt_q == '0) && burst_abort) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    txd_d        = 8'h55;
                    gmii_tx_en_d = 1'b1;
                    if (cnt_q == LEN_W'(6)) begin
                        state_d = StSfd;
                        cnt_d   = '0;
                    end
                end
            end
            StSfd: begin
                txd_d        = 8'hD5;
                gmii_tx_en_d = 1'b1;
                state_d      = StDst;
                cnt_d        = '0;
            end
            StDst: begin
                txd_d        = dst_sh[47:40];
                gmii_tx_en_d = 1'b1;
                crc_upd      = 1'b1;
                if (cnt_q == LEN_W'(5)) begin
                    state_d = StSrc;
                    cnt_d   = '0;
                end
            end
            StSrc: begin
                txd_d        = src_sh[47:40];
                gmii_tx_en_d = 1'b1;
                crc_upd      = 1'b1;
                if (cnt_q == LEN_W'(5)) begin
                    state_d = StType;
                    cnt_d   = '0;
                end
            end
            StType: begin
                txd_d        = cnt_q[0] ? type_q[7:0] : type_q[15:8];
                gmii_tx_en_d = 1'b1;
                crc_upd      = 1'b1;
                if (cnt_q[0]) begin
                    state_d = StPay;
                    cnt_d   = '0;
                end
            end
            StPay: begin
                unique case (pat_q)
                    2'd1:    txd_d = 8'h00;
                    2'd2:    txd_d = pat_byte_q;
                    default: txd_d = cnt_q[7:0] + 8'd1;
                endcase
                gmii_tx_en_d = 1'b1;
                gmii_tx_er_d = err_en_q && (cnt_q == err_idx_q);
                crc_upd      = 1'b1;
                if (cnt_q == len_q - LEN_W'(1)) begin
                    state_d = StFcs;
                    cnt_d   = '0;
                end
            end
            StFcs: begin
                txd_d        = ~crc_sh[7:0];
                gmii_tx_en_d = 1'b1;
                if (cnt_q[1:0] == 2'd3) begin
                    state_d = StIfg;
                    cnt_d   = '0;
                end
            end
            StIfg: begin
                if (cnt_q == IfgLast) begin
                    cnt_d = '0;
                    if (((mode_q == 2'd1) && (frames_left_q != 16'd0)) ||
                        ((mode_q == 2'd2) && tx_en_q)) begin
                        state_d = StPre;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            tx_en_q       <= 1'b0;
            mode_q        <= 2'd0;
            frames_left_q <= 16'd0;
            len_q         <= MinLen;
            type_q        <= 16'd0;
            pat_q         <= 2'd0;
            pat_byte_q    <= 8'd0;
            err_en_q      <= 1'b0;
            err_idx_q     <= '0;
            crc_q         <= 32'hFFFFFFFF;
            txd_q         <= 8'h00;
            gmii_tx_en_q  <= 1'b0;
            gmii_tx_er_q  <= 1'b0;
            busy_q        <= 1'b0;
            done_pend_q   <= 1'b0;
            frame_done_q  <= 1'b0;
            frames_sent_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tx_en_q      <= tx_en;
            txd_q        <= txd_d;
            gmii_tx_en_q <= gmii_tx_en_d;
            gmii_tx_er_q <= gmii_tx_er_d;
            busy_q       <= (state_d != StIdle);

            // Delay by one so the pulse lines up with gmii_tx_en falling
            done_pend_q  <= frame_end;
            frame_done_q <= done_pend_q;
            if (done_pend_q) begin
                frames_sent_q <= frames_sent_q + 16'd1;
            end

            if (start) begin
                mode_q        <= (mode == 2'd3) ? 2'd0 : mode;
                frames_left_q <= burst_cnt;
            end else if (frame_end && (frames_left_q != 16'd0)) begin
                frames_left_q <= frames_left_q - 16'd1;
            end

            if (load_frame) begin
                len_q      <= len_clamped;
                type_q     <= eth_type;
                pat_q      <= pattern_sel;
                pat_byte_q <= fs_now;
                err_en_q   <= err_inj_en && (err_inj_idx < len_clamped);
                err_idx_q  <= err_inj_idx;
                crc_q      <= 32'hFFFFFFFF;
            end else if (crc_upd) begin
                crc_q <= crc_next(crc_q, txd_d);
            end
        end
    end

    assign gmii_txd    = txd_q;
    assign gmii_tx_en  = gmii_tx_en_q;
    assign gmii_tx_er  = gmii_tx_er_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign frames_sent = frames_sent_q;

endmodule
